mux_n_pipe: RTL and testbench

- Parametrised N-input datapath select mux with a registered output and a 2-entry skid buffer, using valid/ready handshake on both sides.
- Successor to the fixed 3-input combinational select used in the RISC-V datapath: generalised in width and input count.
- Adds backpressure, flush, out-of-range select detection and an error counter.
- Sits between operand-forwarding logic and a pipeline stage that may stall.

---
 rtl/mux_n_pipe_if.sv | 27 ++
 rtl/mux_n_pipe.sv | 120 ++++++++++++
 tb/tb_mux_n_pipe.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: upstream select/data and downstream result.
// master drives the inputs and consumes the result; slave is the mux itself.
interface mux_n_pipe_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 3
);
   localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

   logic               in_valid;
   logic               in_ready;
   logic [SEL_W-1:0]   sel;
   logic [N*WIDTH-1:0] d;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   y;
   logic               y_err;

   modport master (
      output in_valid, sel, d, out_ready,
      input  in_ready, out_valid, y, y_err
   );

   modport slave (
      input  in_valid, sel, d, out_ready,
      output in_ready, out_valid, y, y_err
   );
endinterface

// File: rtl/mux_n_pipe.sv
// N-input select mux with a registered output and one skid entry behind it.
// Out-of-range selects pass d[0] flagged as an error and bump a saturating counter.
module mux_n_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   mux_n_pipe_if.slave      bus,
   output logic [CNT_W-1:0] err_cnt
);
   localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

   // Occupancy: ST_ONE = output register only, ST_FULL = output plus skid entry
   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_FULL
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               y_err_q, y_err_d;
   logic [WIDTH-1:0]   skid_data_q, skid_data_d;
   logic               skid_err_q, skid_err_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic               accept;
   logic [WIDTH-1:0]   sel_data;
   logic               sel_err;

   assign bus.in_ready  = (state_q != ST_FULL);
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.y         = y_q;
   assign bus.y_err     = y_err_q;
   assign err_cnt       = err_cnt_q;

   assign accept = bus.in_valid && bus.in_ready;

   always_comb begin
      sel_err  = !(32'(bus.sel) < N);
      sel_data = bus.d[WIDTH-1:0];
      for (int unsigned i = 0; i < N; i++) begin
         if (32'(bus.sel) == i) begin
            sel_data = bus.d[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      y_err_d     = y_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  y_d     = sel_data;
                  y_err_d = sel_err;
               end
            end
            ST_ONE: begin
               if (bus.out_ready) begin
                  if (accept) begin
                     y_d     = sel_data;
                     y_err_d = sel_err;
                  end else begin
                     state_d = ST_EMPTY;
                  end
               end else if (accept) begin
                  state_d     = ST_FULL;
                  skid_data_d = sel_data;
                  skid_err_d  = sel_err;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the skid entry can advance
               if (bus.out_ready) begin
                  state_d = ST_ONE;
                  y_d     = skid_data_q;
                  y_err_d = skid_err_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && sel_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         y_q         <= '0;
         y_err_q     <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         y_err_q     <= y_err_d;
         skid_data_q <= skid_data_d;
         skid_err_q  <= skid_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end
endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and random stimulus for mux_n_pipe against an occupancy/FIFO scoreboard.
module tb_mux_n_pipe;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned N     = 3;
   localparam int unsigned CNT_W = 8;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } item_t;

   logic             clk;
   logic             reset;
   logic             flush;
   logic [CNT_W-1:0] err_cnt;

   mux_n_pipe_if #(.WIDTH(WIDTH), .N(N)) bus ();

   mux_n_pipe #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .bus     (bus),
      .err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   item_t       sb_q[$];
   int unsigned exp_cnt;
   int unsigned n_vec;
   int unsigned n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic item_t offered();
      item_t            it;
      logic [N*WIDTH-1:0] dv;
      int unsigned      s;
      dv = bus.d;
      s  = int'(bus.sel);
      if (s < N) begin
         it.data = dv[s*WIDTH +: WIDTH];
         it.err  = 1'b0;
      end else begin
         it.data = dv[WIDTH-1:0];
         it.err  = 1'b1;
      end
      return it;
   endfunction

   // Advance the model across the next edge, then check the DUT just after it
   task automatic cycle();
      bit    acc;
      bit    emt;
      item_t it;
      it  = offered();
      acc = bus.in_valid && (sb_q.size() < 2);
      emt = (sb_q.size() > 0) && bus.out_ready;
      if (reset) begin
         sb_q.delete();
         exp_cnt = 0;
      end else begin
         if (acc && it.err && exp_cnt < 255) exp_cnt++;
         if (flush) begin
            sb_q.delete();
         end else begin
            if (emt) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(it);
         end
      end
      @(posedge clk);
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'(sb_q.size() < 2));
      chk("out_valid", 64'(bus.out_valid), 64'(sb_q.size() > 0));
      chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
      if (sb_q.size() > 0) begin
         chk("y", 64'(bus.y), 64'(sb_q[0].data));
         chk("y_err", 64'(bus.y_err), 64'(sb_q[0].err));
      end
   endtask

   initial begin
      bit r;
      n_vec        = 0;
      n_fail       = 0;
      exp_cnt      = 0;
      reset        = 1'b1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      bus.sel      = '0;
      bus.d        = '0;
      bus.out_ready = 1'b0;
      cycle();
      cycle();
      chk("reset_y", 64'(bus.y), 64'h0);
      reset = 1'b0;
      cycle();

      // basic select
      bus.out_ready = 1'b1;
      bus.d = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.sel = 2'(i);
         cycle();
      end
      bus.in_valid = 1'b0;
      cycle();
      cycle();

      // out-of-range select, then saturation
      bus.d = {32'h0, 32'h0, 32'h12345678};
      bus.sel = 2'd3;
      bus.in_valid = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      cycle();
      chk("err_cnt_one", 64'(err_cnt), 64'd1);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 300; i++) cycle();
      bus.in_valid = 1'b0;
      cycle();
      cycle();
      chk("err_cnt_sat", 64'(err_cnt), 64'd255);

      // backpressure: A, B fill the pipe, C held off until out_ready rises
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sel       = 2'd1;
      bus.d = {32'hC0C0C0C0, 32'h000000A1, 32'h0};
      cycle();
      bus.d = {32'hC0C0C0C0, 32'h000000B2, 32'h0};
      cycle();
      bus.d = {32'hC0C0C0C0, 32'h000000C3, 32'h0};
      cycle();
      cycle();
      chk("bp_hold_ready", 64'(bus.in_ready), 64'h0);
      chk("bp_hold_y", 64'(bus.y), 64'h000000A1);
      bus.out_ready = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) cycle();

      // random streaming; in_ready must ignore a same-cycle out_ready change
      bus.in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.sel = 2'($urandom_range(0, 3));
         bus.d   = {$urandom, $urandom, $urandom};
         r = 1'($urandom_range(0, 1));
         bus.out_ready = ~r;
         #1;
         chk("in_ready_comb", 64'(bus.in_ready), 64'(sb_q.size() < 2));
         bus.out_ready = r;
         cycle();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();

      // flush with the skid full and an out-of-range item offered alongside
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sel       = 2'd2;
      bus.d = {32'h11111111, 32'h0, 32'h0};
      cycle();
      bus.d = {32'h22222222, 32'h0, 32'h0};
      cycle();
      bus.sel = 2'd3;
      bus.d   = {32'h0, 32'h0, 32'h33333333};
      bus.in_valid = 1'b0;
      #1;
      bus.in_valid = 1'b1;
      flush = 1'b1;
      cycle();
      chk("flush_valid", 64'(bus.out_valid), 64'h0);
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // reset mid-stream with flush and an offered item
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sel       = 2'd1;
      bus.d = {32'h0, 32'hDEADBEEF, 32'h0};
      cycle();
      bus.sel = 2'd3;
      reset = 1'b1;
      flush = 1'b1;
      cycle();
      chk("rst_y", 64'(bus.y), 64'h0);
      chk("rst_y_err", 64'(bus.y_err), 64'h0);
      chk("rst_err_cnt", 64'(err_cnt), 64'h0);
      reset = 1'b0;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
